// File: rtl/friscv_uc_if.sv
// Signals exchanged between the Frisc-V dispenser datapath (master) and its
// control unit (slave).
interface friscv_uc_if;
  logic       liga_frisc_edge;
  logic       liga_suco_1_edge;
  logic       liga_suco_2_edge;
  logic       fim_medida;
  logic       copo_posicionado;
  logic       inicia_medida;
  logic       bomba_1;
  logic       bomba_2;
  logic       pronto;
  logic       sem_copo;
  logic       erro_sensor;
  logic [3:0] db_estado;

  modport master (
    output liga_frisc_edge, liga_suco_1_edge, liga_suco_2_edge,
           fim_medida, copo_posicionado,
    input  inicia_medida, bomba_1, bomba_2, pronto, sem_copo,
           erro_sensor, db_estado
  );

  modport slave (
    input  liga_frisc_edge, liga_suco_1_edge, liga_suco_2_edge,
           fim_medida, copo_posicionado,
    output inicia_medida, bomba_1, bomba_2, pronto, sem_copo,
           erro_sensor, db_estado
  );
endinterface

// File: rtl/friscv_uc.sv
// Frisc-V juice dispenser control unit: power toggle, juice selection, cup
// check, timed filling with periodic re-measurement, and sensor timeout.
module friscv_uc #(
  parameter int CICLOS_BOMBA    = 250_000_000,
  parameter int CICLOS_REMEDIDA = 25_000_000,
  parameter int CICLOS_TIMEOUT  = 50_000_000
) (
  input logic        clock,
  input logic        reset,
  friscv_uc_if.slave bus
);

  localparam int FW = (CICLOS_BOMBA    > 1) ? $clog2(CICLOS_BOMBA)    : 1;
  localparam int RW = (CICLOS_REMEDIDA > 1) ? $clog2(CICLOS_REMEDIDA) : 1;
  localparam int TW = (CICLOS_TIMEOUT  > 1) ? $clog2(CICLOS_TIMEOUT)  : 1;

  localparam logic [FW-1:0] FILL_LAST = FW'(CICLOS_BOMBA - 1);
  localparam logic [RW-1:0] REM_LAST  = RW'(CICLOS_REMEDIDA - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(CICLOS_TIMEOUT - 1);

  typedef enum logic [3:0] {
    DESLIGADO = 4'd0,
    OCIOSO    = 4'd1,
    MEDE      = 4'd2,
    AGUARDA   = 4'd3,
    AVALIA    = 4'd4,
    ENCHE     = 4'd5,
    FIM       = 4'd6,
    SEM_COPO  = 4'd7,
    ERRO      = 4'd8
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic          copo_q, copo_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          suco_req;

  assign suco_req = bus.liga_suco_1_edge | bus.liga_suco_2_edge;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DESLIGADO;
      sel_q   <= '0;
      copo_q  <= 1'b0;
      fill_q  <= '0;
      rem_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      copo_q  <= copo_d;
      fill_q  <= fill_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
    end
  end

  // The power toggle is applied last so it overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DESLIGADO: if (bus.liga_frisc_edge) state_d = OCIOSO;
      OCIOSO:    if (suco_req) state_d = MEDE;
      MEDE:      state_d = AGUARDA;
      AGUARDA: begin
        if (bus.fim_medida)         state_d = AVALIA;
        else if (tmo_q == TMO_LAST) state_d = ERRO;
      end
      AVALIA:    state_d = copo_q ? ENCHE : SEM_COPO;
      ENCHE: begin
        if (bus.fim_medida && !bus.copo_posicionado) state_d = SEM_COPO;
        else if (fill_q == FILL_LAST)                state_d = FIM;
      end
      FIM:       state_d = OCIOSO;
      SEM_COPO:  if (suco_req) state_d = MEDE;
      ERRO:      state_d = ERRO;
      default:   state_d = DESLIGADO;
    endcase
    if (bus.liga_frisc_edge && state_q != DESLIGADO) state_d = DESLIGADO;
  end

  // Counters run only while their state persists, so leaving clears them.
  always_comb begin
    sel_d  = sel_q;
    copo_d = copo_q;
    fill_d = '0;
    rem_d  = '0;
    tmo_d  = '0;
    if (state_d == MEDE && state_q != MEDE)
      sel_d = bus.liga_suco_1_edge ? 2'd1 : 2'd2;
    if (state_q == AGUARDA && bus.fim_medida)
      copo_d = bus.copo_posicionado;
    if (state_q == AGUARDA && state_d == AGUARDA && tmo_q != TMO_LAST)
      tmo_d = tmo_q + TW'(1);
    if (state_q == ENCHE && state_d == ENCHE) begin
      fill_d = (fill_q == FILL_LAST) ? fill_q : fill_q + FW'(1);
      rem_d  = (rem_q == REM_LAST) ? '0 : rem_q + RW'(1);
    end
  end

  always_comb begin
    bus.inicia_medida = 1'b0;
    bus.bomba_1       = 1'b0;
    bus.bomba_2       = 1'b0;
    bus.pronto        = 1'b0;
    bus.sem_copo      = 1'b0;
    bus.erro_sensor   = 1'b0;
    bus.db_estado     = state_q;
    case (state_q)
      MEDE:     bus.inicia_medida = 1'b1;
      ENCHE: begin
        bus.inicia_medida = (rem_q == REM_LAST);
        bus.bomba_1       = (sel_q == 2'd1);
        bus.bomba_2       = (sel_q == 2'd2);
      end
      FIM:      bus.pronto      = 1'b1;
      SEM_COPO: bus.sem_copo    = 1'b1;
      ERRO:     bus.erro_sensor = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: doc/friscv_uc.md
Name: friscv_uc

Overview:
Control unit for the Frisc-V juice dispenser. It sits directly downstream of the dispenser datapath and consumes its edge-detected button pulses, fim_medida and copo_posicionado. It drives the datapath's inicia_medida and the two pump outputs. It sequences the full cycle: power on/off, juice selection, cup check, timed filling with periodic re-measurement, and error/abort handling.

Parameters:
CICLOS_BOMBA, 250_000_000, pump-on duration in clock cycles (5 s at 50 MHz)
CICLOS_REMEDIDA, 25_000_000, period between re-measurements while filling
CICLOS_TIMEOUT, 50_000_000, maximum wait for fim_medida after inicia_medida

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
liga_frisc_edge  in  1  one-cycle power-toggle pulse
liga_suco_1_edge  in  1  one-cycle juice 1 request
liga_suco_2_edge  in  1  one-cycle juice 2 request
fim_medida  in  1  one-cycle measurement-done pulse
copo_posicionado  in  1  cup present; valid on the fim_medida cycle
inicia_medida  out  1  one-cycle measurement start pulse
bomba_1  out  1  pump 1 enable
bomba_2  out  1  pump 2 enable
pronto  out  1  one-cycle pulse on fill completion
sem_copo  out  1  high while waiting after a missing or removed cup
erro_sensor  out  1  high in sensor-timeout state
db_estado  out  4  current state code

Behaviour:
- The interface has one clock. Reset is synchronous and active-high. Reset forces state DESLIGADO, clears all counters and the selection register, and drives every output to 0. Reset has priority over every other input.
- Outputs are Moore outputs, decoded from the state register. db_estado carries the state code.
- State codes:
  - DESLIGADO = 0
  - OCIOSO = 1
  - MEDE = 2
  - AGUARDA = 3
  - AVALIA = 4
  - ENCHE = 5
  - FIM = 6
  - SEM_COPO = 7
  - ERRO = 8
- Unused codes return to DESLIGADO.
- Global rule: liga_frisc_edge in any state other than DESLIGADO moves the FSM to DESLIGADO on the next edge. This rule overrides all other transitions, so the pumps are off one cycle after the pulse.
- DESLIGADO: liga_frisc_edge -> OCIOSO. Suco edges are ignored.
- OCIOSO: a suco_1 edge latches sel=1 and a suco_2 edge latches sel=2, then -> MEDE. If both edges arrive in the same cycle, suco_1 wins.
- MEDE: inicia_medida=1 for this single cycle. Clear the timeout counter, then -> AGUARDA.
- AGUARDA: the timeout counter increments each cycle.
  - fim_medida -> AVALIA.
  - Otherwise, after CICLOS_TIMEOUT cycles in AGUARDA -> ERRO.
  - If fim_medida coincides with the final timeout cycle, fim_medida wins.
- AVALIA: copo_posicionado=1 -> ENCHE. Otherwise -> SEM_COPO.
  - copo_posicionado is registered on the fim_medida cycle, not sampled in AVALIA.
- ENCHE: bomba_1 = (sel==1) and bomba_2 = (sel==2); both pumps are never on together.
  - The fill counter runs for exactly CICLOS_BOMBA cycles, then -> FIM.
  - The re-measure counter pulses inicia_medida for one cycle every CICLOS_REMEDIDA cycles.
  - fim_medida with copo_posicionado=0 -> SEM_COPO next cycle. Fill progress is discarded.
  - No timeout applies in ENCHE.
  - A suco edge during ENCHE is ignored.
- FIM: pronto=1 for one cycle, then -> OCIOSO.
- SEM_COPO: sem_copo=1. A suco edge latches a new sel (same priority rule) -> MEDE.
- ERRO: erro_sensor=1. Only liga_frisc_edge or reset exits this state.
- Counters are sized by $clog2 of their parameter. They saturate or clear on state exit and never wrap.
- Latency:
  - suco edge at cycle N -> inicia_medida at N+1.
  - fim_medida at cycle M (cup present) -> pump on at M+2.
  - Pump high for exactly CICLOS_BOMBA cycles; pronto follows at the next cycle.

Test Plan:
(Parameters for the bench: CICLOS_BOMBA=20, CICLOS_REMEDIDA=8, CICLOS_TIMEOUT=30.)
- Normal fill:
  - Stimulus: reset; liga_frisc_edge; suco_1 edge at cycle 10; fim_medida with copo=1 at cycle 15.
  - Response: inicia_medida at 11; bomba_1 high cycles 17–36; bomba_2 stays 0; pronto at 37; db_estado returns to 1.
- Simultaneous request:
  - Stimulus: suco_1 and suco_2 edges in the same cycle in OCIOSO.
  - Response: bomba_1 drives, not bomba_2.
- No cup, then retry:
  - Stimulus: fim_medida with copo=0; then suco_2 edge; then fim_medida with copo=1.
  - Response: sem_copo=1 after the first measurement; bomba_2 runs for 20 cycles after the retry.
- Cup removed mid-fill:
  - Stimulus: during ENCHE, respond to the re-measure inicia_medida (at fill cycle 8) with fim_medida, copo=0.
  - Response: pump off the next cycle; sem_copo=1; pronto never asserts.
- Sensor timeout:
  - Stimulus: no fim_medida for 30 cycles after inicia_medida.
  - Response: erro_sensor=1, db_estado=8. A later suco edge is ignored; liga_frisc_edge -> db_estado=0.
- Abort and reset priority:
  - Stimulus: liga_frisc_edge mid-fill; separately, reset asserted in ENCHE.
  - Response: each case gives all outputs 0 and db_estado=0 one cycle later.
